// File: rtl/int_ctrl_if.sv
// ---------------------------------------------------------------------------
// int_ctrl_if
// Purpose : bundles the CPU-facing signals of the interrupt controller.
// Signals :
//   irq      [3:0]  interrupt request lines (bit 3 highest priority)
//   gie             global interrupt enable
//   maskWe          mask register write strobe
//   maskDin  [3:0]  new mask value (1 = line enabled)
//   ack             CPU accepts the presented interrupt (one-cycle pulse)
//   rti             CPU returns from the current handler (one-cycle pulse)
//   req             interrupt request to the CPU
//   addrInt  [15:0] vector of the presented interrupt, 0 when req is low
//   pend     [3:0]  pending register
//   isr      [3:0]  in-service register
//   mask     [3:0]  mask register readback
// Modports: master = CPU/system side, slave = controller side.
// ---------------------------------------------------------------------------
interface int_ctrl_if;
  logic [3:0]  irq;
  logic        gie;
  logic        maskWe;
  logic [3:0]  maskDin;
  logic        ack;
  logic        rti;
  logic        req;
  logic [15:0] addrInt;
  logic [3:0]  pend;
  logic [3:0]  isr;
  logic [3:0]  mask;

  modport master (
    output irq, gie, maskWe, maskDin, ack, rti,
    input  req, addrInt, pend, isr, mask
  );

  modport slave (
    input  irq, gie, maskWe, maskDin, ack, rti,
    output req, addrInt, pend, isr, mask
  );
endinterface

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl
// Purpose : four-line prioritised, nestable interrupt controller. Rising
//           edges on the request lines become pending bits; the highest
//           eligible line is presented to the CPU with its vector address
//           until the CPU acknowledges it (moves to in-service) or the line
//           stops being eligible (withdraw). RTI retires the highest
//           in-service level.
// Ports   :
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus     int_ctrl_if.slave (irq/gie/mask/ack/rti in, req/addr/regs out)
// ---------------------------------------------------------------------------
module int_ctrl (
  input  logic      clk_i,
  input  logic      rst_ni,
  int_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  win_q, win_d;
  logic [3:0]  irq_q;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  isr_q, isr_d;
  logic [3:0]  mask_q, mask_d;

  logic [3:0]  rise;
  logic [3:0]  isrAllow;
  logic [3:0]  eligible;
  logic        anyEligible;
  logic [1:0]  winner;
  logic [3:0]  isrTop;
  logic [3:0]  winOneHot;
  logic        ackTake;

  // Map a line index onto its handler vector address.
  function automatic logic [15:0] vectorOf(input logic [1:0] line);
    logic [15:0] v;
    case (line)
      2'd0:    v = 16'hFFF0;
      2'd1:    v = 16'hFFF2;
      2'd2:    v = 16'hFFFA;
      default: v = 16'hFFFC;
    endcase
    return v;
  endfunction

  // Edge detection: a line counts once per low-to-high transition. Since
  // irq_q clears in reset, a line already high at release counts as an edge.
  assign rise = bus.irq & ~irq_q;

  // A line may only preempt if no in-service bit sits at its own index or
  // above; with ISR empty every line is allowed.
  always_comb begin
    isrAllow = '0;
    for (int i = 0; i < 4; i++) begin
      isrAllow[i] = ~|(isr_q >> i);
    end
  end

  assign eligible    = {4{bus.gie}} & pend_q & mask_q & isrAllow;
  assign anyEligible = |eligible;

  // Highest-index eligible line wins.
  always_comb begin
    winner = 2'd0;
    if (eligible[3])      winner = 2'd3;
    else if (eligible[2]) winner = 2'd2;
    else if (eligible[1]) winner = 2'd1;
    else                  winner = 2'd0;
  end

  // One-hot of the highest in-service bit, i.e. the level RTI retires.
  always_comb begin
    isrTop = '0;
    if (isr_q[3])      isrTop = 4'b1000;
    else if (isr_q[2]) isrTop = 4'b0100;
    else if (isr_q[1]) isrTop = 4'b0010;
    else if (isr_q[0]) isrTop = 4'b0001;
  end

  assign winOneHot = 4'b0001 << win_q;

  // Presentation FSM. ACK outranks the withdraw check, and an ACK seen
  // while idle simply does nothing.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ackTake = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyEligible) begin
          state_d = PRESENT;
          win_d   = winner;
        end
      end
      PRESENT: begin
        if (bus.ack) begin
          ackTake = 1'b1;
          state_d = IDLE;
        end else if (!eligible[win_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register next-state: a fresh edge on the acknowledged line re-arms its
  // pending bit in the same cycle. RTI works on the pre-edge ISR, so it can
  // coexist with an ACK setting the (necessarily higher) winning bit.
  always_comb begin
    pend_d = (pend_q & ~(ackTake ? winOneHot : 4'b0000)) | rise;
    isr_d  = (isr_q & ~(bus.rti ? isrTop : 4'b0000)) |
             (ackTake ? winOneHot : 4'b0000);
    mask_d = bus.maskWe ? bus.maskDin : mask_q;
  end

  // All state registers; reset also drops any latched winner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      irq_q   <= 4'b0000;
      pend_q  <= 4'b0000;
      isr_q   <= 4'b0000;
      mask_q  <= 4'hF;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      irq_q   <= bus.irq;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
      mask_q  <= mask_d;
    end
  end

  // Outputs come straight from registers so they are stable for the whole
  // presentation and vanish the instant reset asserts.
  assign bus.req     = (state_q == PRESENT);
  assign bus.addrInt = (state_q == PRESENT) ? vectorOf(win_q) : 16'h0000;
  assign bus.pend    = pend_q;
  assign bus.isr     = isr_q;
  assign bus.mask    = mask_q;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL: CLK  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: RESET_N  in  1  asynchronous, active-low reset; while low, all state is cleared immediately.
REQ-003 SHALL: IRQ  in  4  interrupt request lines; bit 3 is the highest priority, bit 0 the lowest.
REQ-004 SHALL: GIE  in  1  global interrupt enable.
REQ-005 SHALL: MASK_WE  in  1  write strobe for the mask register.
REQ-006 SHALL: MASK_DIN  in  4  new mask value; a 1 enables the corresponding line.
REQ-007 SHALL: ACK  in  1  one-cycle pulse from the CPU accepting the presented interrupt.
REQ-008 SHALL: RTI  in  1  one-cycle pulse from the CPU signalling return from the current handler.
REQ-009 SHALL: REQ  out  1  interrupt request to the CPU.
REQ-010 SHALL: ADDRInt  out  16  vector address of the presented interrupt; 16'h0000 when REQ=0.
REQ-011 SHALL: PEND  out  4  pending register.
REQ-012 SHALL: ISR  out  4  in-service register.
REQ-013 SHALL: MASK  out  4  mask register readback.

Function
REQ-014 SHALL: Pending set: IRQ[i] is sampled each edge into IRQ_Q[i]; PEND[i] sets at the edge where IRQ[i]=1 and IRQ_Q[i]=0 (rising edge only); a line held high produces exactly one event.
REQ-015 SHALL: Pending clear: PEND[i] clears only on ACK acceptance of line i; if a new edge on line i coincides with that ACK, PEND[i] stays 1.
REQ-016 SHALL: MASK loads MASK_DIN at an edge with MASK_WE=1; PEND bits set regardless of MASK.
REQ-017 SHALL: Eligibility: line i is eligible when GIE=1, PEND[i]=1, MASK[i]=1 and i is greater than the index of the highest set ISR bit (any i is eligible when ISR=0).
REQ-018 SHALL: Winner: the highest-index eligible line.
REQ-019 SHALL: Vector map: 0->16'hFFF0, 1->16'hFFF2, 2->16'hFFFA, 3->16'hFFFC.
REQ-020 SHALL: FSM has two states, IDLE and PRESENT.
REQ-021 SHALL: IDLE: REQ=0 and ADDRInt=0; if any line is eligible at an edge, latch the winner in WIN and go to PRESENT (REQ=1 the cycle after PEND is visible).
REQ-022 SHALL: PRESENT: REQ=1 and ADDRInt=vector(WIN), both held stable; WIN does not change even if a higher-priority line becomes eligible.
REQ-023 SHALL: PRESENT with ACK=1: set ISR[WIN], clear PEND[WIN], go to IDLE; REQ drops the next cycle and a further eligible line is presented one cycle after that.
REQ-024 SHALL: Withdraw: in PRESENT, if WIN becomes ineligible through GIE=0, MASK[WIN]=0 (after MASK_WE), or RTI state change, go to IDLE without ACK and keep PEND[WIN]; an ACK in the same cycle takes priority over the withdraw.
REQ-025 SHALL: ACK while in IDLE is ignored.
REQ-026 SHALL: RTI clears the highest set ISR bit; RTI with ISR=0 is ignored.
REQ-027 SHALL: RTI and ACK in the same cycle: RTI clears the highest bit of the pre-edge ISR and ACK sets ISR[WIN]; both take effect at that edge.
REQ-028 SHALL: Nesting: a higher-priority line may be presented while ISR is nonzero; equal- or lower-priority lines wait until RTI lowers the ISR level.

Reset
REQ-029 SHALL: RESET_N=0 asynchronously forces REQ=0, ADDRInt=0, PEND=0, ISR=0, IRQ_Q=0, MASK=4'hF and state IDLE.
REQ-030 SHALL: Reset mid-PRESENT drops REQ at once and discards the latched winner.
REQ-031 SHALL: A line already high at reset release is treated as a rising edge.

Verification
REQ-032 SHALL: Single request: IRQ=0001 rising, no ACK -> PEND=0001 and REQ=1 with ADDRInt=FFF0 one cycle later; ACK -> ISR=0001, PEND=0, REQ=0.
REQ-033 SHALL: Simultaneous requests: IRQ 0000->0101 -> vector FFFA presented first; after ACK and RTI, FFF0 is presented.
REQ-034 SHALL: Nesting: with ISR=0010, IRQ[3] rises -> FFFC presented and ACK gives ISR=1010; IRQ[0] rises -> no REQ until two RTI pulses have given ISR=0.
REQ-035 SHALL: Mask withdraw: while presenting line 2, MASK_WE with MASK_DIN=1011 -> REQ=0 the next cycle with PEND[2] kept; restoring MASK=1111 -> FFFA presented again.
REQ-036 SHALL: Corner events: ACK and RTI in the same cycle with ISR=0100 and WIN=3 -> ISR=1000; RESET_N pulsed low while REQ=1 -> all outputs 0 immediately and MASK=1111.
